// File: rtl/btn_pkg.sv
// Shared definitions for the button debouncer: channel FSM state encoding,
// agreement-counter width and a small state decode helper.
package btn_pkg;

  // Width of the per-channel agreement counter (holds up to STABLE_TICKS=15).
  localparam int CNT_W = 4;

  // Channel FSM state, kept as plain 2-bit constants for legacy tools.
  typedef logic [1:0] btn_state_t;

  localparam btn_state_t ST_IDLE         = 2'd0;
  localparam btn_state_t ST_PRESS_WAIT   = 2'd1;
  localparam btn_state_t ST_HELD         = 2'd2;
  localparam btn_state_t ST_RELEASE_WAIT = 2'd3;

  // Debounced level implied by a state: the button counts as down from the
  // moment a press is accepted until a release is accepted.
  function automatic logic state_level(input btn_state_t st);
    return (st == ST_HELD) || (st == ST_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/btn_tick_gen.sv
// Sample-tick generator: free-running counter 0..TICK_DIV-1 with a
// registered one-clk tick while the counter sits at TICK_DIV-1.
module btn_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  // tick is registered, so it is loaded one count early to line up with LAST
  localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

  logic [CW-1:0] count;

  // Wrap-around divider plus registered tick decode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= (count == LAST) ? '0 : count + CW'(1);
      tick  <= (count == PRE);
    end
  end

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel button debouncer. Each raw input is synchronized, then a
// per-channel FSM qualifies level changes over STABLE_TICKS agreeing samples
// taken on a shared sample tick. Press/release are one-clk registered pulses.
// Optional feature: define BTN_AUTOREPEAT_EN to re-emit btn_press every
// REPEAT_TICKS held samples while a button stays down.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 1_000_000,
  parameter int STABLE_TICKS = 4,
  parameter int REPEAT_TICKS = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             tick
);

  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int               RPT_W    = $clog2(REPEAT_TICKS + 1);
  localparam logic [RPT_W-1:0] REPEAT_C = RPT_W'(REPEAT_TICKS);
`endif

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  btn_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Two-flop synchronizer on every raw button line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  genvar i;
  for (i = 0; i < N_BTN; i++) begin : g_ch
    btn_state_t       st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             s;
    logic             press_nxt, rel_nxt;
    logic             press_q, rel_q, lvl_q;
`ifdef BTN_AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt, rpt_nxt, rpt_inc;
    assign rpt_inc = rpt + RPT_W'(1);
`endif

    assign s       = sync2[i];
    assign cnt_inc = cnt + CNT_ONE;

    // Next-state decode; only advances on sample ticks, holds otherwise
    always_comb begin
      st_nxt    = st;
      cnt_nxt   = cnt;
      press_nxt = 1'b0;
      rel_nxt   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_nxt   = rpt;
`endif
      if (tick) begin
        case (st)
          ST_IDLE: begin
            if (s) begin
              st_nxt  = ST_PRESS_WAIT;
              cnt_nxt = CNT_ONE;
            end
          end
          ST_PRESS_WAIT: begin
            if (s) begin
              if (cnt_inc == STABLE_C) begin
                st_nxt    = ST_HELD;
                cnt_nxt   = '0;
                press_nxt = 1'b1;
              end else begin
                cnt_nxt = cnt_inc;
              end
            end else begin
              st_nxt  = ST_IDLE;
              cnt_nxt = '0;
            end
          end
          ST_HELD: begin
            if (!s) begin
              st_nxt  = ST_RELEASE_WAIT;
              cnt_nxt = CNT_ONE;
`ifdef BTN_AUTOREPEAT_EN
              rpt_nxt = '0;
`endif
            end else begin
`ifdef BTN_AUTOREPEAT_EN
              // Held sample: advance repeat count, fire on reaching the period
              if (rpt_inc == REPEAT_C) begin
                press_nxt = 1'b1;
                rpt_nxt   = '0;
              end else begin
                rpt_nxt = rpt_inc;
              end
`endif
            end
          end
          ST_RELEASE_WAIT: begin
            if (!s) begin
              if (cnt_inc == STABLE_C) begin
                st_nxt  = ST_IDLE;
                cnt_nxt = '0;
                rel_nxt = 1'b1;
              end else begin
                cnt_nxt = cnt_inc;
              end
            end else begin
              // Release glitch: fall back to HELD silently
              st_nxt  = ST_HELD;
              cnt_nxt = '0;
            end
          end
          default: begin
            st_nxt  = ST_IDLE;
            cnt_nxt = '0;
          end
        endcase
      end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st      <= ST_IDLE;
        cnt     <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        lvl_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        rpt     <= '0;
`endif
      end else begin
        st      <= st_nxt;
        cnt     <= cnt_nxt;
        press_q <= press_nxt;
        rel_q   <= rel_nxt;
        lvl_q   <= state_level(st_nxt);
`ifdef BTN_AUTOREPEAT_EN
        rpt     <= rpt_nxt;
`endif
      end
    end

    assign btn_level[i]   = lvl_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce (TICK_DIV=4, STABLE_TICKS=3,
// REPEAT_TICKS=5, N_BTN=4): table of level/pulse-count vectors plus
// hand-written sequences for exact pulse timing, bounce, reset and repeat.
module tb_btn_debounce;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int RT = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;
  logic         tick;

  always #5 clk = ~clk;

  btn_debounce #(
    .N_BTN(N), .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_TICKS(RT)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .tick(tick)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse bookkeeping, updated on every falling edge
  int           press_cnt [N];
  int           rel_cnt   [N];
  int           rule_bad = 0;
  logic [N-1:0] press_prev = '0, rel_prev = '0, last_press_vec = '0;

  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      press_cnt[c] += int'(btn_press[c]);
      rel_cnt[c]   += int'(btn_release[c]);
    end
    if ((btn_press & btn_release) != 0 || (btn_press & press_prev) != 0 ||
        (btn_release & rel_prev) != 0)
      rule_bad++;
    press_prev = btn_press;
    rel_prev   = btn_release;
    if (btn_press != 0) last_press_vec = btn_press;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One clock, landing just after the falling edge
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Advance to the next cycle on which tick is visible (edge not yet taken)
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 20);
    if (!tick) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [N-1:0]      raw;
    int                ticks;
    logic [N-1:0]      lvl;
    logic [N-1:0][3:0] press;  // expected new press pulses, nibble per channel
    logic [N-1:0][3:0] rel;    // expected new release pulses
  } vec_t;

  vec_t tbl [9];
  int   pb [N];
  int   rb [N];
  int   first_tick, last_tick, nticks, gap_bad, out_bad, exp_rpt;

  task automatic snap();
    for (int c = 0; c < N; c++) begin
      pb[c] = press_cnt[c];
      rb[c] = rel_cnt[c];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{raw: 4'b0000, ticks: 4, lvl: 4'b0000, press: 16'h0000, rel: 16'h0001};
    tbl[1] = '{raw: 4'b0100, ticks: 5, lvl: 4'b0100, press: 16'h0100, rel: 16'h0000};
    tbl[2] = '{raw: 4'b0000, ticks: 2, lvl: 4'b0100, press: 16'h0000, rel: 16'h0000};
    tbl[3] = '{raw: 4'b0100, ticks: 3, lvl: 4'b0100, press: 16'h0000, rel: 16'h0000};
    tbl[4] = '{raw: 4'b0000, ticks: 4, lvl: 4'b0000, press: 16'h0000, rel: 16'h0100};
    tbl[5] = '{raw: 4'b1010, ticks: 4, lvl: 4'b1010, press: 16'h1010, rel: 16'h0000};
    tbl[6] = '{raw: 4'b0000, ticks: 4, lvl: 4'b0000, press: 16'h0000, rel: 16'h1010};
    tbl[7] = '{raw: 4'b1111, ticks: 3, lvl: 4'b1111, press: 16'h1111, rel: 16'h0000};
    tbl[8] = '{raw: 4'b0000, ticks: 3, lvl: 4'b0000, press: 16'h0000, rel: 16'h1111};

    // Reset state
    repeat (3) step();
    chk("rst_level",   32'(btn_level),   32'h0);
    chk("rst_press",   32'(btn_press),   32'h0);
    chk("rst_release", 32'(btn_release), 32'h0);
    chk("rst_tick",    32'(tick),        32'h0);
    rst = 1'b0;

    // Idle: tick period and quiet outputs over 100 clocks
    first_tick = -1; last_tick = -1; nticks = 0; gap_bad = 0; out_bad = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (tick) begin
        if (first_tick < 0) first_tick = k;
        if (last_tick >= 0 && k - last_tick != TD) gap_bad++;
        last_tick = k;
        nticks++;
      end
      if ((btn_level | btn_press | btn_release) != 0) out_bad++;
    end
    chk("idle_first_tick", 32'(first_tick), 32'd3);
    chk("idle_tick_count", 32'(nticks),     32'd25);
    chk("idle_tick_gap",   32'(gap_bad),    32'd0);
    chk("idle_outputs",    32'(out_bad),    32'd0);

    // Clean press on channel 0: pulse right after the 3rd high sample
    wait_tick();
    btn_raw[0] = 1'b1;
    repeat (3) wait_tick();
    chk("c0_press_early", 32'(btn_press), 32'h0);
    chk("c0_level_early", 32'(btn_level), 32'h0);
    step();
    chk("c0_press",       32'(btn_press), 32'h1);
    chk("c0_level",       32'(btn_level), 32'h1);
    step();
    chk("c0_press_width", 32'(btn_press), 32'h0);
    chk("c0_no_release",  32'(btn_release), 32'h0);

    // Vector table: level and pulse-count deltas per step
    for (int v = 0; v < 9; v++) begin
      snap();
      btn_raw = tbl[v].raw;
      repeat (tbl[v].ticks) wait_tick();
      step();
      step();
      chk($sformatf("vec%0d_level", v), 32'(btn_level), 32'(tbl[v].lvl));
      for (int c = 0; c < N; c++) begin
        chk($sformatf("vec%0d_press%0d", v, c), 32'(press_cnt[c] - pb[c]), 32'(tbl[v].press[c]));
        chk($sformatf("vec%0d_rel%0d", v, c),   32'(rel_cnt[c] - rb[c]),   32'(tbl[v].rel[c]));
      end
      if (v == 7) chk("simultaneous_press", 32'(last_press_vec), 32'hf);
    end

    // Bounce on channel 1: toggling every 5 clks never qualifies
    snap();
    for (int k = 0; k < 60; k++) begin
      btn_raw[1] = ((k / 5) % 2 == 0);
      step();
    end
    chk("bounce_press", 32'(press_cnt[1] - pb[1]), 32'd0);
    chk("bounce_rel",   32'(rel_cnt[1] - rb[1]),   32'd0);
    chk("bounce_level", 32'(btn_level),            32'h0);
    btn_raw[1] = 1'b1;
    repeat (4) wait_tick();
    step();
    step();
    chk("bounce_settle_press", 32'(press_cnt[1] - pb[1]), 32'd1);
    chk("bounce_settle_level", 32'(btn_level),            32'h2);
    btn_raw[1] = 1'b0;
    repeat (4) wait_tick();
    step();
    step();
    chk("bounce_release", 32'(rel_cnt[1] - rb[1]), 32'd1);

    // Reset while channel 3 is in PRESS_WAIT with cnt=2
    snap();
    wait_tick();
    btn_raw[3] = 1'b1;
    wait_tick();
    wait_tick();
    step();
    rst = 1'b1;
    step();
    chk("midrst_outputs", 32'({btn_level, btn_press, btn_release}), 32'h0);
    chk("midrst_tick",    32'(tick), 32'h0);
    step();
    rst = 1'b0;
    wait_tick();
    wait_tick();
    step();
    step();
    chk("postrst_no_pulse", 32'(press_cnt[3] - pb[3]), 32'd0);
    wait_tick();
    chk("postrst_press_early", 32'(btn_press), 32'h0);
    step();
    chk("postrst_press", 32'(btn_press), 32'h8);
    chk("postrst_level", 32'(btn_level), 32'h8);
    btn_raw[3] = 1'b0;
    repeat (4) wait_tick();
    step();
    step();
    chk("postrst_release", 32'(rel_cnt[3] - rb[3]), 32'd1);

    // Channel 0 held 20 ticks after acceptance
`ifdef BTN_AUTOREPEAT_EN
    exp_rpt = 5;
`else
    exp_rpt = 1;
`endif
    snap();
    wait_tick();
    btn_raw[0] = 1'b1;
    repeat (3) wait_tick();
    repeat (20) wait_tick();
    step();
    step();
    chk("hold_press_count", 32'(press_cnt[0] - pb[0]), 32'(exp_rpt));
    chk("hold_level",       32'(btn_level),            32'h1);
    btn_raw[0] = 1'b0;
    repeat (4) wait_tick();
    step();
    step();
    chk("hold_release", 32'(rel_cnt[0] - rb[0]), 32'd1);

    chk("pulse_rules", 32'(rule_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
